// File: rtl/axil_mitm_rd_pkg.sv
// Shared definitions for the AXI4-lite read-path man-in-the-middle block:
// FSM state encodings and AXI response codes.
package axil_mitm_rd_pkg;

  // One-hot FSM encoding.
  typedef enum logic [1:0] {
    StIdle = 2'b01,
    StResp = 2'b10
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

endpackage

// File: rtl/axil_register_rd.sv
// AXI4-lite read register slice: AR channel is a simple one-entry buffer,
// R channel is a combinational bypass.
module axil_register_rd #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [2:0]            arprot_q;
  logic                  arvalid_q;

  // Buffer accepts only when empty, so arready is a pure register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q  <= '0;
      arprot_q  <= '0;
      arvalid_q <= 1'b0;
    end else if (s_axil_arvalid && !arvalid_q) begin
      araddr_q  <= s_axil_araddr;
      arprot_q  <= s_axil_arprot;
      arvalid_q <= 1'b1;
    end else if (m_axil_arready) begin
      arvalid_q <= 1'b0;
    end
  end

  assign s_axil_arready = !arvalid_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = arprot_q;
  assign m_axil_arvalid = arvalid_q;

  assign s_axil_rdata   = m_axil_rdata;
  assign s_axil_rresp   = m_axil_rresp;
  assign s_axil_rvalid  = m_axil_rvalid;
  assign m_axil_rready  = s_axil_rready;

endmodule

// File: rtl/axil_mitm_rd.sv
// AXI4-lite read-channel man-in-the-middle: one outstanding read, all outputs registered.
// Optional fault injection on returned data when AXIL_MITM_RD_CORRUPT_EN is defined.
module axil_mitm_rd
  import axil_mitm_rd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef AXIL_MITM_RD_CORRUPT_EN
  input  logic                  corrupt_en,
  input  logic [DATA_WIDTH-1:0] corrupt_mask,
`endif
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  if (STRB_WIDTH * 8 != DATA_WIDTH) begin : g_strb_check
    $error("STRB_WIDTH must equal DATA_WIDTH/8");
  end

  state_e                state_q, state_d;
  logic                  s_arready_q, s_arready_d;
  logic                  s_rvalid_q, s_rvalid_d;
  logic [DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;
  logic [1:0]            s_rresp_q, s_rresp_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;
  logic                  int_arvalid_q, int_arvalid_d;
  logic                  int_rready_q, int_rready_d;

  logic                  int_arready;
  logic [DATA_WIDTH-1:0] int_rdata;
  logic [1:0]            int_rresp;
  logic                  int_rvalid;
  logic                  ar_hs;
  logic                  r_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      s_arready_q   <= 1'b0;
      s_rvalid_q    <= 1'b0;
      s_rdata_q     <= '0;
      s_rresp_q     <= '0;
      araddr_q      <= '0;
      arprot_q      <= '0;
      int_arvalid_q <= 1'b0;
      int_rready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_arready_q   <= s_arready_d;
      s_rvalid_q    <= s_rvalid_d;
      s_rdata_q     <= s_rdata_d;
      s_rresp_q     <= s_rresp_d;
      araddr_q      <= araddr_d;
      arprot_q      <= arprot_d;
      int_arvalid_q <= int_arvalid_d;
      int_rready_q  <= int_rready_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    s_arready_d   = s_arready_q;
    s_rdata_d     = s_rdata_q;
    s_rresp_d     = s_rresp_q;
    araddr_d      = araddr_q;
    arprot_d      = arprot_q;
    int_arvalid_d = int_arvalid_q;
    int_rready_d  = int_rready_q;

    ar_hs = s_axil_arvalid && s_arready_q;
    r_hs  = int_rvalid && int_rready_q;

    s_rvalid_d = s_rvalid_q && !s_axil_rready;
    if (int_arvalid_q && int_arready) begin
      int_arvalid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        s_arready_d = !int_arvalid_q;
        if (ar_hs) begin
          araddr_d      = s_axil_araddr;
          arprot_d      = s_axil_arprot;
          int_arvalid_d = 1'b1;
          s_arready_d   = 1'b0;
          // Hold off the downstream beat while an earlier response is still pending.
          int_rready_d  = !s_rvalid_d;
          state_d       = StResp;
        end
      end
      StResp: begin
        int_rready_d = !s_rvalid_d;
        if (r_hs) begin
`ifdef AXIL_MITM_RD_CORRUPT_EN
          if (corrupt_en) begin
            s_rdata_d = int_rdata ^ corrupt_mask;
            s_rresp_d = RespSlverr;
          end else begin
            s_rdata_d = int_rdata;
            s_rresp_d = int_rresp;
          end
`else
          s_rdata_d = int_rdata;
          s_rresp_d = int_rresp;
`endif
          s_rvalid_d   = 1'b1;
          int_rready_d = 1'b0;
          s_arready_d  = !int_arvalid_d;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign s_axil_arready = s_arready_q;
  assign s_axil_rvalid  = s_rvalid_q;
  assign s_axil_rdata   = s_rdata_q;
  assign s_axil_rresp   = s_rresp_q;

  axil_register_rd #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axil_araddr  (araddr_q),
    .s_axil_arprot  (arprot_q),
    .s_axil_arvalid (int_arvalid_q),
    .s_axil_arready (int_arready),
    .s_axil_rdata   (int_rdata),
    .s_axil_rresp   (int_rresp),
    .s_axil_rvalid  (int_rvalid),
    .s_axil_rready  (int_rready_q),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arprot  (m_axil_arprot),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready)
  );

endmodule

// File: tb/tb_axil_mitm_rd.sv
// Directed self-checking bench for axil_mitm_rd; the bench plays both upstream master
// and downstream slave. Corrupt test included when AXIL_MITM_RD_CORRUPT_EN is defined.
module tb_axil_mitm_rd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axil_araddr = '0;
  logic [2:0]  s_axil_arprot = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready = 1'b0;
  logic [31:0] m_axil_rdata = '0;
  logic [1:0]  m_axil_rresp = '0;
  logic        m_axil_rvalid = 1'b0;
  logic        m_axil_rready;
`ifdef AXIL_MITM_RD_CORRUPT_EN
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_mask = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_mitm_rd u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef AXIL_MITM_RD_CORRUPT_EN
    .corrupt_en     (corrupt_en),
    .corrupt_mask   (corrupt_mask),
`endif
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arprot  (s_axil_arprot),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arprot  (m_axil_arprot),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Upstream master issues one AR once arready is seen.
  task automatic ar_send(input logic [31:0] addr);
    for (int i = 0; i < 50 && !s_axil_arready; i++) step();
    check_eq("ar_send_arready", s_axil_arready, 1);
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    step();
    s_axil_arvalid = 1'b0;
  endtask

  // Downstream slave waits for the forwarded AR and accepts it.
  task automatic slave_ar(input logic [31:0] exp_addr);
    for (int i = 0; i < 50 && !m_axil_arvalid; i++) step();
    check_eq("slave_ar_valid", m_axil_arvalid, 1);
    check_eq("slave_ar_addr", m_axil_araddr, exp_addr);
    m_axil_arready = 1'b1;
    step();
    m_axil_arready = 1'b0;
  endtask

  // Downstream slave returns one R beat once rready is seen.
  task automatic slave_r(input logic [31:0] data, input logic [1:0] resp);
    for (int i = 0; i < 50 && !m_axil_rready; i++) step();
    check_eq("slave_r_rready", m_axil_rready, 1);
    m_axil_rdata  = data;
    m_axil_rresp  = resp;
    m_axil_rvalid = 1'b1;
    step();
    m_axil_rvalid = 1'b0;
  endtask

  // Upstream master waits for the response, checks it and consumes it.
  task automatic master_r(input logic [31:0] exp_data, input logic [1:0] exp_resp);
    for (int i = 0; i < 50 && !s_axil_rvalid; i++) step();
    check_eq("master_r_valid", s_axil_rvalid, 1);
    check_eq("master_r_data", s_axil_rdata, exp_data);
    check_eq("master_r_resp", s_axil_rresp, exp_resp);
    s_axil_rready = 1'b1;
    step();
    s_axil_rready = 1'b0;
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;

    // Reset state
    step();
    check_eq("rst_arready", s_axil_arready, 0);
    check_eq("rst_rvalid", s_axil_rvalid, 0);
    check_eq("rst_rdata", s_axil_rdata, 0);
    check_eq("rst_rresp", s_axil_rresp, 0);
    check_eq("rst_m_arvalid", m_axil_arvalid, 0);
    check_eq("rst_m_rready", m_axil_rready, 0);
    rst_n = 1'b1;
    step();
    check_eq("idle_arready", s_axil_arready, 1);

    // Single read with explicit latency checks
    s_axil_araddr  = 32'h0000_1000;
    s_axil_arprot  = 3'b010;
    s_axil_arvalid = 1'b1;
    step();
    s_axil_arvalid = 1'b0;
    check_eq("t1_arready_low", s_axil_arready, 0);
    check_eq("t1_m_arvalid_t1", m_axil_arvalid, 0);
    check_eq("t1_m_rready", m_axil_rready, 1);
    step();
    check_eq("t1_m_arvalid_t2", m_axil_arvalid, 1);
    check_eq("t1_m_araddr", m_axil_araddr, 32'h0000_1000);
    check_eq("t1_m_arprot", m_axil_arprot, 3'b010);
    m_axil_arready = 1'b1;
    step();
    m_axil_arready = 1'b0;
    check_eq("t1_m_arvalid_clr", m_axil_arvalid, 0);
    m_axil_rdata  = 32'hDEAD_BEEF;
    m_axil_rresp  = 2'b00;
    m_axil_rvalid = 1'b1;
    step();
    m_axil_rvalid = 1'b0;
    check_eq("t1_s_rvalid", s_axil_rvalid, 1);
    check_eq("t1_s_rdata", s_axil_rdata, 32'hDEAD_BEEF);
    check_eq("t1_s_rresp", s_axil_rresp, 2'b00);
    check_eq("t1_s_arready_back", s_axil_arready, 1);
    check_eq("t1_m_rready_drop", m_axil_rready, 0);
    s_axil_rready = 1'b1;
    step();
    s_axil_rready = 1'b0;
    check_eq("t1_s_rvalid_clr", s_axil_rvalid, 0);

    // Error pass-through
    ar_send(32'h0000_1004);
    slave_ar(32'h0000_1004);
    slave_r(32'h0, 2'b11);
    master_r(32'h0, 2'b11);

    // Backpressure with an overlapping second read
    ar_send(32'h0000_3000);
    slave_ar(32'h0000_3000);
    slave_r(32'hAAAA_5555, 2'b00);
    ar_send(32'h0000_2000);
    slave_ar(32'h0000_2000);
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = 32'h0000_9999;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_m_rready", m_axil_rready, 0);
      check_eq("bp_s_rdata", s_axil_rdata, 32'hAAAA_5555);
      check_eq("bp_arready", s_axil_arready, 0);
      step();
    end
    s_axil_arvalid = 1'b0;
    master_r(32'hAAAA_5555, 2'b00);
    slave_r(32'h5555_AAAA, 2'b10);
    master_r(32'h5555_AAAA, 2'b10);
    check_eq("bp_no_dup", s_axil_rvalid, 0);
    check_eq("bp_no_extra_ar", m_axil_arvalid, 0);

    // Reset mid-transaction
    ar_send(32'h0000_4000);
    step();
    check_eq("rst_pre_arvalid", m_axil_arvalid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_arready", s_axil_arready, 0);
    check_eq("rst_mid_rvalid", s_axil_rvalid, 0);
    check_eq("rst_mid_m_arvalid", m_axil_arvalid, 0);
    check_eq("rst_mid_m_rready", m_axil_rready, 0);
    step();
    rst_n = 1'b1;
    ar_send(32'h0000_5000);
    slave_ar(32'h0000_5000);
    slave_r(32'h0BAD_F00D, 2'b00);
    master_r(32'h0BAD_F00D, 2'b00);

`ifdef AXIL_MITM_RD_CORRUPT_EN
    ar_send(32'h0000_6000);
    slave_ar(32'h0000_6000);
    corrupt_en   = 1'b1;
    corrupt_mask = 32'h0000_00FF;
    slave_r(32'h1234_5678, 2'b00);
    corrupt_en   = 1'b0;
    corrupt_mask = '0;
    master_r(32'h1234_5687, 2'b10);
`endif

    // Random stall soak: data and response derived from address
    for (int n = 0; n < 40; n++) begin
      addr = {16'h0, 8'(n), 8'($urandom_range(0, 255))};
      data = {addr[15:0], ~addr[15:0]};
      resp = 2'(n % 4);
      ar_send(addr);
      repeat ($urandom_range(0, 3)) step();
      slave_ar(addr);
      repeat ($urandom_range(0, 3)) step();
      slave_r(data, resp);
      repeat ($urandom_range(0, 3)) step();
      master_r(data, resp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
